// File: rtl/vga_receiver.sv
// rtl/vga_receiver.sv - VGA stream receiver: coordinate recovery, geometry check, lock FSM
module vga_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1048576
) (
  input  logic       iClk_50,
  input  logic       iRst,
  input  logic       iPixEn,
  input  logic [9:0] iVGA_R,
  input  logic [9:0] iVGA_G,
  input  logic [9:0] iVGA_B,
  input  logic       iVGA_HSync,
  input  logic       iVGA_VSync,
  input  logic       iVGA_Blank,
  output logic [9:0] oR,
  output logic [9:0] oG,
  output logic [9:0] oB,
  output logic [9:0] oRow,
  output logic [9:0] oCol,
  output logic       oValid,
  output logic       oFrameStart,
  output logic       oLocked,
  output logic       oErr,
  output logic [9:0] oLineWidth,
  output logic [9:0] oLineCount
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [9:0]      H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0]      V_LIM   = 10'(V_ACTIVE);
  localparam logic [9:0]      SAT     = 10'h3FF;
  localparam logic [7:0]      LOCK_N  = 8'(LOCK_FRAMES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

  state_t          state;
  logic            hs_q, vs_q, bl_q;
  logic [9:0]      col, row;
  logic            frame_bad;
  logic [7:0]      good;
  logic [WD_W-1:0] wd;

  logic       hs_fall, vs_fall, act, eol;
  logic [9:0] col_inc, row_inc;
  logic       eol_bad, judge_bad;
  logic [7:0] good_inc;

  // Strobe qualification, saturating increments and line/frame verdicts
  always_comb begin
    hs_fall   = iPixEn & hs_q & ~iVGA_HSync;
    vs_fall   = iPixEn & vs_q & ~iVGA_VSync;
    act       = iPixEn & iVGA_Blank;
    // line ends on the first blanked strobe following active video
    eol       = iPixEn & ~iVGA_Blank & bl_q;
    col_inc   = (col == SAT) ? col : col + 10'd1;
    row_inc   = (row == SAT) ? row : row + 10'd1;
    eol_bad   = (col != H_LIM) || (col == SAT);
    judge_bad = frame_bad || (row != V_LIM) || (row == SAT);
    good_inc  = good + 8'd1;
  end

  // Sync edge history, pixel counters and registered pixel/geometry outputs
  always_ff @(posedge iClk_50) begin
    if (iRst) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      bl_q       <= 1'b0;
      col        <= '0;
      row        <= '0;
      frame_bad  <= 1'b0;
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
      oRow       <= '0;
      oCol       <= '0;
      oValid     <= 1'b0;
      oLineWidth <= '0;
      oLineCount <= '0;
    end else begin
      oValid <= 1'b0;
      if (iPixEn) begin
        hs_q <= iVGA_HSync;
        vs_q <= iVGA_VSync;
        bl_q <= iVGA_Blank;
      end
      if (act) begin
        oR     <= iVGA_R;
        oG     <= iVGA_G;
        oB     <= iVGA_B;
        oRow   <= row;
        oCol   <= col;
        oValid <= (state != SEEK) && (col < H_LIM) && (row < V_LIM);
      end
      if (vs_fall) begin
        // VSync wins over a coincident HSync: both counters restart
        oLineCount <= row;
        row        <= '0;
        col        <= '0;
        frame_bad  <= 1'b0;
      end else begin
        if (hs_fall) begin
          col <= '0;
        end else if (act) begin
          col <= col_inc;
        end
        if (eol) begin
          oLineWidth <= col;
          row        <= row_inc;
          if (eol_bad) begin
            frame_bad <= 1'b1;
          end
        end
      end
    end
  end

  // Lock FSM with frame judgement, strobe watchdog and registered status pulses
  always_ff @(posedge iClk_50) begin
    if (iRst) begin
      state       <= SEEK;
      good        <= '0;
      wd          <= '0;
      oLocked     <= 1'b0;
      oErr        <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oErr        <= 1'b0;
      oFrameStart <= 1'b0;
      if (vs_fall) begin
        wd <= '0;
        case (state)
          SEEK: begin
            // first edge only establishes frame alignment, nothing is judged
            state   <= TRACK;
            good    <= '0;
            oLocked <= 1'b0;
          end
          TRACK: begin
            oFrameStart <= 1'b1;
            if (judge_bad) begin
              good <= '0;
              oErr <= 1'b1;
            end else if (good_inc == LOCK_N) begin
              good    <= good_inc;
              state   <= LOCKED;
              oLocked <= 1'b1;
            end else begin
              good <= good_inc;
            end
          end
          LOCKED: begin
            oFrameStart <= 1'b1;
            if (judge_bad) begin
              state   <= TRACK;
              good    <= '0;
              oErr    <= 1'b1;
              oLocked <= 1'b0;
            end
          end
          default: begin
            state   <= SEEK;
            good    <= '0;
            oLocked <= 1'b0;
          end
        endcase
      end else if (iPixEn) begin
        if (wd == WD_LAST) begin
          // stream lost: fall back silently and wait for a fresh VSync
          wd      <= '0;
          state   <= SEEK;
          good    <= '0;
          oLocked <= 1'b0;
        end else begin
          wd <= wd + WD_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_receiver.sv
// tb/tb_vga_receiver.sv - directed-vector bench for vga_receiver
module tb_vga_receiver;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int HT = H + 4;
  localparam int VT = V + 3;
  localparam int T  = 200;

  logic       iClk_50 = 1'b0;
  logic       iRst, iPixEn;
  logic [9:0] iVGA_R, iVGA_G, iVGA_B;
  logic       iVGA_HSync, iVGA_VSync, iVGA_Blank;
  logic [9:0] oR, oG, oB, oRow, oCol, oLineWidth, oLineCount;
  logic       oValid, oFrameStart, oLocked, oErr;

  int n_vec = 0;
  int n_mis = 0;
  int err_cnt = 0;
  int fs_cnt = 0;
  int tl = -1;
  int th = -1;
  logic [9:0] s_r, s_g, s_b, s_row, s_col, i_r;
  logic       s_valid, i_valid;
  logic [9:0] t_r, t_g, t_b, t_row, t_col, t_ir, lw_cap;
  logic       t_valid, t_ivalid;

  vga_receiver #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2), .TIMEOUT(T)) dut (
    .iClk_50(iClk_50), .iRst(iRst), .iPixEn(iPixEn),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .iVGA_HSync(iVGA_HSync), .iVGA_VSync(iVGA_VSync), .iVGA_Blank(iVGA_Blank),
    .oR(oR), .oG(oG), .oB(oB), .oRow(oRow), .oCol(oCol), .oValid(oValid),
    .oFrameStart(oFrameStart), .oLocked(oLocked), .oErr(oErr),
    .oLineWidth(oLineWidth), .oLineCount(oLineCount)
  );

  always #10 iClk_50 = ~iClk_50;

  always @(negedge iClk_50) begin
    if (oErr) err_cnt++;
    if (oFrameStart) fs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                        input logic hs, input logic vs, input logic bl);
    iVGA_R = r; iVGA_G = g; iVGA_B = b;
    iVGA_HSync = hs; iVGA_VSync = vs; iVGA_Blank = bl;
    iPixEn = 1'b1;
    @(posedge iClk_50); #1;
    s_r = oR; s_g = oG; s_b = oB; s_row = oRow; s_col = oCol; s_valid = oValid;
    iPixEn = 1'b0;
    @(posedge iClk_50); #1;
    i_r = oR; i_valid = oValid;
  endtask

  task automatic run_frame(input int l0, input int short_ln, input int blank_ln, input int rst_ln);
    logic bl;
    int   base;
    for (int l = l0; l < VT; l++) begin
      for (int h = 0; h < HT; h++) begin
        if (l == rst_ln && h == 4) begin
          iRst = 1'b1;
          @(posedge iClk_50); #1;
          iRst = 1'b0;
          chk("rst_mid_rgb", 32'({oR, oG, oB}), 32'd0);
          chk("rst_mid_pos", 32'({oRow, oCol}), 32'd0);
          chk("rst_mid_flags", 32'({oValid, oFrameStart, oLocked, oErr}), 32'd0);
          chk("rst_mid_geom", 32'({oLineWidth, oLineCount}), 32'd0);
        end
        bl   = (l < V) && (h < H) && (l != blank_ln) && !(l == short_ln && h == H - 1);
        base = l * 16 + h;
        strobe((l == 0 && h == 0) ? 10'd400 : 10'(base), 10'(base + 100),
               (l == 0 && h == 0) ? 10'd800 : 10'(base + 200),
               !(h == H + 1 || h == H + 2), !(l == V + 1 || l == V + 2), bl);
        if (l == tl && h == th) begin
          t_r = s_r; t_g = s_g; t_b = s_b; t_row = s_row; t_col = s_col;
          t_valid = s_valid; t_ir = i_r; t_ivalid = i_valid;
        end
        if (l == short_ln && h == HT - 1) lw_cap = oLineWidth;
      end
    end
  endtask

  initial begin
    iRst = 1'b1; iPixEn = 1'b0;
    iVGA_R = '0; iVGA_G = '0; iVGA_B = '0;
    iVGA_HSync = 1'b1; iVGA_VSync = 1'b1; iVGA_Blank = 1'b0;
    repeat (3) @(posedge iClk_50);
    #1 iRst = 1'b0;
    @(posedge iClk_50); #1;
    chk("reset_rgb", 32'({oR, oG, oB}), 32'd0);
    chk("reset_pos", 32'({oRow, oCol}), 32'd0);
    chk("reset_flags", 32'({oValid, oFrameStart, oLocked, oErr}), 32'd0);
    chk("reset_geom", 32'({oLineWidth, oLineCount}), 32'd0);

    // three perfect frames: first VSync only aligns, locking on the third
    run_frame(0, -1, -1, -1);
    chk("f1_locked", 32'(oLocked), 32'd0);
    chk("f1_fs", 32'(fs_cnt), 32'd0);
    run_frame(0, -1, -1, -1);
    chk("f2_locked", 32'(oLocked), 32'd0);
    tl = 3; th = H - 1;
    run_frame(0, -1, -1, -1);
    chk("f3_locked", 32'(oLocked), 32'd1);
    chk("f3_err", 32'(err_cnt), 32'd0);
    chk("f3_fs", 32'(fs_cnt), 32'd2);
    chk("f3_width", 32'(oLineWidth), 32'd8);
    chk("f3_lines", 32'(oLineCount), 32'd4);
    chk("last_px_pos", 32'({t_row, t_col}), 32'({10'd3, 10'd7}));
    chk("last_px_valid", 32'(t_valid), 32'd1);

    // short line while locked
    tl = -1;
    run_frame(0, 1, -1, -1);
    chk("short_width", 32'(lw_cap), 32'd7);
    chk("short_err", 32'(err_cnt), 32'd1);
    chk("short_locked", 32'(oLocked), 32'd0);
    chk("short_fs", 32'(fs_cnt), 32'd3);

    // missing line, then relock with two good frames
    run_frame(0, -1, 2, -1);
    chk("miss_lines", 32'(oLineCount), 32'd3);
    chk("miss_err", 32'(err_cnt), 32'd2);
    run_frame(0, -1, -1, -1);
    chk("relock1_locked", 32'(oLocked), 32'd0);
    run_frame(0, -1, -1, -1);
    chk("relock2_locked", 32'(oLocked), 32'd1);

    // first pixel latency and colour, plus a mid-frame pixel
    tl = 0; th = 0;
    run_frame(0, -1, -1, -1);
    chk("px00_rgb", 32'({t_r, t_g, t_b}), 32'({10'd400, 10'd100, 10'd800}));
    chk("px00_pos", 32'({t_row, t_col}), 32'd0);
    chk("px00_valid", 32'(t_valid), 32'd1);
    chk("px00_idle_valid", 32'(t_ivalid), 32'd0);
    chk("px00_idle_hold", 32'(t_ir), 32'd400);
    chk("px00_fs", 32'(fs_cnt), 32'd7);
    tl = 2; th = 5;
    run_frame(0, -1, -1, -1);
    chk("px25_rgb", 32'({t_r, t_g, t_b}), 32'({10'd37, 10'd137, 10'd237}));
    chk("px25_pos", 32'({t_row, t_col}), 32'({10'd2, 10'd5}));
    chk("px25_locked", 32'(oLocked), 32'd1);

    // watchdog: 23 strobes already elapsed since the last VSync fall
    for (int j = 0; j < T - 24; j++) strobe(10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    chk("wd_before", 32'(oLocked), 32'd1);
    strobe(10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    chk("wd_after", 32'(oLocked), 32'd0);
    for (int j = 0; j < 23; j++) strobe(10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    chk("wd_err", 32'(err_cnt), 32'd2);
    tl = 1; th = 1;
    run_frame(0, -1, -1, -1);
    chk("seek_valid", 32'(t_valid), 32'd0);
    chk("seek_fs", 32'(fs_cnt), 32'd8);
    chk("seek_locked", 32'(oLocked), 32'd0);
    tl = -1;
    run_frame(0, -1, -1, -1);
    run_frame(0, -1, -1, -1);
    chk("wd_relock", 32'(oLocked), 32'd1);

    // reset mid-frame at row 2, then relock after 1+2 VSync falls
    run_frame(0, -1, -1, 2);
    chk("rst_f0_locked", 32'(oLocked), 32'd0);
    run_frame(0, -1, -1, -1);
    chk("rst_f1_locked", 32'(oLocked), 32'd0);
    run_frame(0, -1, -1, -1);
    chk("rst_f2_locked", 32'(oLocked), 32'd1);
    chk("rst_f2_lines", 32'(oLineCount), 32'd4);
    chk("final_err", 32'(err_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
